// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: FSM encoding and
// debounce length defaults for synthesis and for simulation benches.
package btn_pkg;

  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b10;
  localparam logic [1:0] WAIT_LOW  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE_LOW  = IDLE_LOW,
    S_WAIT_HIGH = WAIT_HIGH,
    S_IDLE_HIGH = IDLE_HIGH,
    S_WAIT_LOW  = WAIT_LOW
  } btn_state_e;

  localparam int NB_DBC_DEF     = 20;
  // 10 ms at 100 MHz
  localparam int DBC_CYCLES_SYN = 1000000;
  localparam int SIM_DBC_CYCLES = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, qualify FSM with hold counter, and
// registered level / rise / fall / busy outputs.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int NB_DBC     = NB_DBC_DEF,
  parameter int DBC_CYCLES = DBC_CYCLES_SYN
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  if ((DBC_CYCLES < 2) || (longint'(DBC_CYCLES) > ((64'sd1 <<< NB_DBC) - 64'sd1))) begin : g_bad_cfg
    $error("btn_debounce_ch: DBC_CYCLES=%0d does not fit NB_DBC=%0d", DBC_CYCLES, NB_DBC);
  end

  localparam logic [NB_DBC-1:0] CNT_LAST = NB_DBC'(DBC_CYCLES - 1);
  localparam logic [NB_DBC-1:0] CNT_ONE  = NB_DBC'(1);

  logic              sync1_q, sync2_q;
  btn_state_e        state_q, state_d;
  logic [NB_DBC-1:0] cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_IDLE_LOW: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_HIGH: begin
        // any reversal drops all accumulated credit
        if (!sync2_q) begin
          state_d = S_IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_IDLE_HIGH: begin
        level_d = 1'b1;
        if (!sync2_q) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = S_IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_busy  = busy_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NB_BTN independent raw push-buttons into clean levels plus
// single-cycle rise/fall pulses; all outputs are registered.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NB_BTN     = 4,
  parameter int NB_DBC     = NB_DBC_DEF,
  parameter int DBC_CYCLES = DBC_CYCLES_SYN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_rise,
  output logic [NB_BTN-1:0] o_btn_fall,
  output logic [NB_BTN-1:0] o_busy
);

  for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .NB_DBC     (NB_DBC),
      .DBC_CYCLES (DBC_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (i_btn[gi]),
      .o_level (o_btn_level[gi]),
      .o_rise  (o_btn_rise[gi]),
      .o_fall  (o_btn_fall[gi]),
      .o_busy  (o_busy[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a run-length reference model pushes the expected
// outputs for every cycle into a scoreboard that is drained after the edge.
module tb_btn_debounce;

  localparam int DBC = btn_pkg::SIM_DBC_CYCLES;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] i_btn;
  logic [3:0] o_btn_level, o_btn_rise, o_btn_fall, o_busy;

  btn_debounce #(
    .NB_BTN     (4),
    .NB_DBC     (20),
    .DBC_CYCLES (DBC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_btn       (i_btn),
    .o_btn_level (o_btn_level),
    .o_btn_rise  (o_btn_rise),
    .o_btn_fall  (o_btn_fall),
    .o_busy      (o_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] busy;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: synchroniser copy, accepted level, run of disagreeing samples
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int         m_run[4];

  int         n_rise[4];
  int         n_fall[4];
  logic [3:0] rise_seen, fall_seen, busy_seen;

  int         g_hi[4];
  int         g_lo[4];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int c = 0; c < 4; c++) begin
      n_rise[c] = 0;
      n_fall[c] = 0;
    end
    rise_seen = '0;
    fall_seen = '0;
    busy_seen = '0;
  endtask

  task automatic tick();
    exp_t e;
    e = '0;
    if (reset) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int c = 0; c < 4; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (m_s2[c] != m_lvl[c]) m_run[c]++;
        else                     m_run[c] = 0;
        if (m_run[c] == DBC) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) e.rise[c] = 1'b1;
          else          e.fall[c] = 1'b1;
          m_run[c] = 0;
        end
        e.busy[c] = (m_run[c] != 0);
      end
      m_s2 = m_s1;
      m_s1 = i_btn;
    end
    e.level = m_lvl;
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("level", o_btn_level, e.level);
    chk("rise", o_btn_rise, e.rise);
    chk("fall", o_btn_fall, e.fall);
    chk("busy", o_busy, e.busy);
    chk("no_overlap", o_btn_rise & o_btn_fall, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      n_rise[c] += int'(o_btn_rise[c]);
      n_fall[c] += int'(o_btn_fall[c]);
    end
    rise_seen |= o_btn_rise;
    fall_seen |= o_btn_fall;
    busy_seen |= o_busy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      m_run[c] = 0;
      g_hi[c]  = 0;
      g_lo[c]  = 0;
    end
    clr_stats();

    // button held through reset, then released reset
    reset = 1'b1;
    i_btn = 4'b1111;
    repeat (3) begin
      tick();
      chk("rst_outs", o_btn_level | o_btn_rise | o_btn_fall | o_busy, 4'b0000);
    end
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_rise_early", o_btn_rise, 4'b0000);
    tick();
    chk("rst_rise_c6", o_btn_rise, 4'b1111);
    tick();
    chk("rst_rise_gone", o_btn_rise, 4'b0000);
    chk("rst_level", o_btn_level, 4'b1111);

    i_btn = 4'b0000;
    repeat (10) tick();
    chk("all_released", o_btn_level, 4'b0000);

    // clean press/release on ch0
    clr_stats();
    i_btn = 4'b0001;
    repeat (5) tick();
    chk("press_early", o_btn_rise, 4'b0000);
    tick();
    chk("press_rise0", o_btn_rise, 4'b0001);
    chk("press_level0", o_btn_level, 4'b0001);
    repeat (14) tick();
    i_btn = 4'b0000;
    repeat (5) tick();
    chk("rel_early", o_btn_fall, 4'b0000);
    tick();
    chk("rel_fall0", o_btn_fall, 4'b0001);
    chk("rel_level0", o_btn_level, 4'b0000);
    repeat (4) tick();
    chk_int("ch0_rise_cnt", n_rise[0], 1);
    chk_int("ch0_fall_cnt", n_fall[0], 1);
    chk("ch123_quiet", rise_seen | fall_seen, 4'b0001);

    // bounce on ch1: high 3, low 1, high 2, low
    clr_stats();
    i_btn = 4'b0010; repeat (3) tick();
    i_btn = 4'b0000; repeat (1) tick();
    i_btn = 4'b0010; repeat (2) tick();
    i_btn = 4'b0000; repeat (8) tick();
    chk("bnc_no_pulse", rise_seen | fall_seen, 4'b0000);
    chk("bnc_busy_seen", busy_seen, 4'b0010);
    chk("bnc_level", o_btn_level, 4'b0000);
    i_btn = 4'b0010;
    repeat (10) tick();
    chk_int("bnc_hold_rise", n_rise[1], 1);
    chk("bnc_hold_level", o_btn_level, 4'b0010);
    i_btn = 4'b0000;
    repeat (10) tick();

    // reset while ch2 is qualifying, button kept held
    i_btn = 4'b0100;
    repeat (4) tick();
    chk("mq_busy", o_busy, 4'b0100);
    clr_stats();
    reset = 1'b1;
    tick();
    chk("mq_rst_outs", o_btn_level | o_btn_rise | o_btn_fall | o_busy, 4'b0000);
    reset = 1'b0;
    repeat (5) tick();
    chk("mq_rise_early", rise_seen | fall_seen, 4'b0000);
    tick();
    chk("mq_rise", o_btn_rise, 4'b0100);
    i_btn = 4'b0000;
    repeat (10) tick();

    // simultaneous press on ch1 and ch3
    clr_stats();
    i_btn = 4'b1010;
    repeat (5) tick();
    tick();
    chk("sim_rise", o_btn_rise, 4'b1010);
    chk("sim_level", o_btn_level, 4'b1010);
    i_btn = 4'b0000;
    repeat (10) tick();
    chk("sim_released", o_btn_level, 4'b0000);

    // random glitches of 1..3 cycles, each followed by at least one low cycle
    clr_stats();
    repeat (10000) begin
      logic [3:0] b;
      b = '0;
      for (int c = 0; c < 4; c++) begin
        if (g_hi[c] > 0) begin
          b[c] = 1'b1;
          g_hi[c]--;
          if (g_hi[c] == 0) g_lo[c] = $urandom_range(1, 4);
        end else if (g_lo[c] > 0) begin
          g_lo[c]--;
        end else if ($urandom_range(0, 2) == 0) begin
          b[c] = 1'b1;
          g_hi[c] = $urandom_range(0, 2);
          if (g_hi[c] == 0) g_lo[c] = $urandom_range(1, 4);
        end
      end
      i_btn = b;
      tick();
    end
    i_btn = 4'b0000;
    repeat (4) tick();
    chk("rnd_no_pulse", rise_seen | fall_seen, 4'b0000);
    chk("rnd_level", o_btn_level, 4'b0000);
    chk_int("rnd_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
